// File: rtl/key_patch_scheduler.sv
// key_patch_scheduler
// Turns decoded keyboard events into patch writes for the two patchable
// instruction-memory words: word 16 (pending flag, bit 0) and word 18
// (5-bit key code). Key codes are buffered in a small FIFO. A new key is
// only posted after the running program has fetched the previous one.
//
// Ports:
//   CLK          system clock, all state on rising edge
//   nReset       synchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     decoded 5-bit key code
//   pc_addr      current instruction fetch address
//   WriteEnable  one-cycle patch write strobe (registered)
//   keyboard     patch value {code, pending} (registered)
//   busy         high whenever the sequencer is not IDLE
//   fifo_full    FIFO holds FIFO_DEPTH entries
//   overflow     sticky: a key was dropped (cleared only by reset)
module key_patch_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] FLAG_ADDR  = 32'h0000_0040,
    parameter logic [31:0] ACK_ADDR   = 32'h0000_0048,
    parameter logic [4:0]  IDLE_CODE  = 5'd0
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [31:0] pc_addr,
    output logic        WriteEnable,
    output logic [5:0]  keyboard,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int              PW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW:0]     CNT_ZERO   = (PW+1)'(0);
    localparam logic [PW:0]     FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [4:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          we_r;
    logic [5:0]    kb_r;
    logic          ovf_r;

    logic          guard_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [4:0]    head_s;

    // Guard, FIFO status and push/pop decisions.
    always_comb begin
        guard_s = (pc_addr != FLAG_ADDR) && (pc_addr != ACK_ADDR);
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == FULL_COUNT);
        head_s  = fifo_mem_r[rd_ptr_r];
        // The !we_r term keeps a post from launching right after another
        // write, so WriteEnable is never high on two consecutive cycles.
        if ((state_r == IDLE) && !empty_s && guard_s && !we_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        // A full FIFO still accepts a key on the edge that pops its head.
        if (key_valid && (!full_s || pop_s)) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (key_valid) begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= key_code;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Patch sequencer with registered write strobe and patch value.
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            state_r <= INIT;
            we_r    <= 1'b0;
            kb_r    <= 6'b00_0000;
        end else begin
            case (state_r)
                INIT: begin
                    if (guard_s) begin
                        we_r    <= 1'b1;
                        kb_r    <= {IDLE_CODE, 1'b0};
                        state_r <= IDLE;
                    end else begin
                        we_r    <= 1'b0;
                    end
                end
                IDLE: begin
                    if (pop_s) begin
                        we_r    <= 1'b1;
                        kb_r    <= {head_s, 1'b1};
                        state_r <= WAIT_ACK;
                    end else begin
                        we_r    <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    we_r <= 1'b0;
                    if (pc_addr == ACK_ADDR) begin
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Clear the pending flag, keep the code visible.
                    if (guard_s) begin
                        we_r    <= 1'b1;
                        kb_r    <= {kb_r[5:1], 1'b0};
                        state_r <= IDLE;
                    end else begin
                        we_r    <= 1'b0;
                    end
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= INIT;
                end
            endcase
        end
    end

    assign WriteEnable = we_r;
    assign keyboard    = kb_r;
    assign overflow    = ovf_r;
    assign busy        = (state_r != IDLE);
    assign fifo_full   = full_s;

endmodule

// File: tb/tb_key_patch_scheduler.sv
module tb_key_patch_scheduler;

    logic        CLK;
    logic        nReset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [31:0] pc_addr;
    logic        WriteEnable;
    logic [5:0]  keyboard;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    key_patch_scheduler dut (
        .CLK         (CLK),
        .nReset      (nReset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pc_addr     (pc_addr),
        .WriteEnable (WriteEnable),
        .keyboard    (keyboard),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [5:0] exp_q[$];   // expected patch writes, in order
    int         mc;         // model FIFO occupancy while the DUT is frozen
    logic       ovf_exp;
    logic       prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0040;
            1:       return 32'h0000_0048;
            2:       return 32'h0000_0044;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge CLK) begin
        if (WriteEnable === 1'b1) begin
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got keyboard 0x%0h expected no write", keyboard);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if (keyboard !== e) $display("FAIL write_value: got 0x%0h expected 0x%0h", keyboard, e);
                else n_pass++;
            end
        end
        prev_we = (WriteEnable === 1'b1);
    end

    // Key push while the sequencer is frozen (no pops possible).
    task automatic push_frozen(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        if (mc < 4) begin
            exp_q.push_back({code, 1'b1});
            exp_q.push_back({code, 1'b0});
            mc++;
        end else begin
            ovf_exp = 1'b1;
        end
        tick();
        key_valid = 1'b0;
    endtask

    // Let the program run with random fetch addresses until all writes land.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            pc_addr = rand_pc();
            tick();
            n++;
        end
        chk("drain_complete", exp_q.size(), 32'd0);
        pc_addr = 32'h0000_004C;
        repeat (3) tick();
        mc = 0;
    endtask

    initial begin
        logic [4:0] c;
        nReset = 1'b0; key_valid = 1'b0; key_code = 5'd0; pc_addr = 32'd0;
        mc = 0; ovf_exp = 1'b0;
        repeat (2) tick();
        chk("rst_we", {31'd0, WriteEnable}, 32'd0);
        chk("rst_keyboard", {26'd0, keyboard}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        // Post-reset clear write.
        exp_q.push_back(6'b00_0000);
        nReset = 1'b1;
        repeat (4) tick();
        chk("init_clear_done", exp_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_we", {31'd0, WriteEnable}, 32'd0);

        // Single key latency: accepted at E0, pulse E1..E2.
        key_valid = 1'b1; key_code = 5'h03;
        exp_q.push_back(6'b00_0111);
        exp_q.push_back(6'b00_0110);
        tick();
        key_valid = 1'b0;
        tick();
        chk("single_we_e1", {31'd0, WriteEnable}, 32'd1);
        chk("single_kb_e1", {26'd0, keyboard}, 32'h07);
        chk("single_busy", {31'd0, busy}, 32'd1);
        pc_addr = 32'h0000_0048;
        tick();
        pc_addr = 32'h0000_004C;
        tick();
        chk("release_we", {31'd0, WriteEnable}, 32'd1);
        chk("release_kb", {26'd0, keyboard}, 32'h06);
        tick();
        chk("release_idle", {31'd0, busy}, 32'd0);

        // Guard: flag-word fetch blocks the post.
        pc_addr = 32'h0000_0040;
        push_frozen(5'h0A);
        repeat (3) begin
            chk("guard_hold_we", {31'd0, WriteEnable}, 32'd0);
            tick();
        end
        pc_addr = 32'h0000_0044;
        tick();
        chk("guard_post_we", {31'd0, WriteEnable}, 32'd1);
        chk("guard_post_kb", {26'd0, keyboard}, 32'h15);
        drain(400);

        // Ordering of three back-to-back keys.
        pc_addr = 32'h0000_0040;
        push_frozen(5'd1);
        push_frozen(5'd2);
        push_frozen(5'd3);
        drain(400);

        // Full FIFO, simultaneous push/pop, then a dropped key.
        pc_addr = 32'h0000_0040;
        for (int i = 0; i < 4; i++) push_frozen(5'($urandom));
        chk("full_after_4", {31'd0, fifo_full}, 32'd1);
        chk("no_ovf_yet", {31'd0, overflow}, 32'd0);
        c = 5'($urandom);
        pc_addr = 32'd0; key_valid = 1'b1; key_code = c;
        exp_q.push_back({c, 1'b1});
        exp_q.push_back({c, 1'b0});
        tick();
        key_valid = 1'b0;
        chk("pushpop_full", {31'd0, fifo_full}, 32'd1);
        chk("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
        pc_addr = 32'h0000_004C;
        key_valid = 1'b1; key_code = 5'h1F;
        tick();
        key_valid = 1'b0;
        ovf_exp = 1'b1;
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        drain(600);

        // Randomised rounds: frozen fill, then free-running drain.
        for (int r = 0; r < 20; r++) begin
            int n;
            pc_addr = 32'h0000_0040;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                push_frozen(5'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            chk("rand_fifo_full", {31'd0, fifo_full}, {31'd0, (mc == 4)});
            chk("rand_overflow", {31'd0, overflow}, {31'd0, ovf_exp});
            drain(600);
        end

        // Reset in WAIT_ACK with two keys queued.
        pc_addr = 32'h0000_0040;
        push_frozen(5'h11);
        push_frozen(5'h12);
        push_frozen(5'h13);
        pc_addr = 32'h0000_004C;
        repeat (3) tick();
        chk("midop_busy", {31'd0, busy}, 32'd1);
        nReset = 1'b0;
        exp_q.delete();
        tick();
        chk("midop_fifo_empty", {31'd0, fifo_full}, 32'd0);
        chk("midop_overflow", {31'd0, overflow}, 32'd0);
        chk("midop_busy_init", {31'd0, busy}, 32'd1);
        exp_q.push_back(6'b00_0000);
        nReset = 1'b1;
        drain(100);
        repeat (30) begin
            pc_addr = rand_pc();
            tick();
        end
        chk("midop_no_posts", exp_q.size(), 32'd0);
        chk("midop_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
